// File: rtl/fp_pkg.sv
// Shared single-precision helpers for the FP execute path: format constants,
// sequencer state encoding and field pack/unpack functions.
package fp_pkg;

   localparam int DEF_EXP_W  = 8;
   localparam int DEF_FRAC_W = 23;
   localparam int WORD_W     = 1 + DEF_EXP_W + DEF_FRAC_W;
   localparam int BIAS       = 127;

   localparam logic [DEF_EXP_W-1:0] EXP_MAX = '1;
   localparam logic [WORD_W-1:0]    QNAN    = 32'h7FC0_0000;

   // Sequencer states shared by the multi-cycle FP units.
   typedef enum logic [2:0] {
      IDLE,
      ALIGN,
      ADDSUB,
      NORM,
      DONE
   } state_e;

   // Unpacked view of a default-format word; man carries the hidden bit.
   typedef struct packed {
      logic                  sign;
      logic [DEF_EXP_W-1:0]  exp;
      logic [DEF_FRAC_W:0]   man;
      logic                  is_zero;
      logic                  is_special;
   } fp_fields_t;

   // Split a word into fields; zero exponent flushes the mantissa to zero.
   function automatic fp_fields_t fp_unpack_word(input logic [WORD_W-1:0] w);
      fp_fields_t f;
      f.sign       = w[WORD_W-1];
      f.exp        = w[WORD_W-2 -: DEF_EXP_W];
      f.is_zero    = (f.exp == '0);
      f.is_special = (f.exp == EXP_MAX);
      f.man        = f.is_zero ? '0 : {1'b1, w[DEF_FRAC_W-1:0]};
      return f;
   endfunction

   // Assemble a word from sign, biased exponent and fraction.
   function automatic logic [WORD_W-1:0] fp_pack(input logic s,
                                                input logic [DEF_EXP_W-1:0] e,
                                                input logic [DEF_FRAC_W-1:0] f);
      return {s, e, f};
   endfunction

endpackage

// File: rtl/fp_unpack.sv
// Field splitter for one IEEE-754 operand: sign, exponent, mantissa with
// hidden bit (denormals flushed to zero), plus zero and Inf/NaN flags.
module fp_unpack #(
   parameter int EXP_W  = fp_pkg::DEF_EXP_W,
   parameter int FRAC_W = fp_pkg::DEF_FRAC_W
) (
   input  logic [EXP_W+FRAC_W:0] word,
   output logic                  sign,
   output logic [EXP_W-1:0]      exp,
   output logic [FRAC_W:0]       man,
   output logic                  is_zero,
   output logic                  is_special
);

   assign sign       = word[EXP_W+FRAC_W];
   assign exp        = word[EXP_W+FRAC_W-1 -: EXP_W];
   assign is_zero    = (exp == '0);
   assign is_special = (exp == {EXP_W{1'b1}});
   assign man        = is_zero ? '0 : {1'b1, word[FRAC_W-1:0]};

endmodule

// File: rtl/fsub_seq.sv
// Multi-cycle IEEE-754 subtractor, result = a - b. Captures operands on an
// accepted start, aligns the smaller operand one bit per cycle, adds or
// subtracts magnitudes, normalises one bit per cycle and truncates.
module fsub_seq
   import fp_pkg::*;
#(
   parameter int EXP_W  = DEF_EXP_W,
   parameter int FRAC_W = DEF_FRAC_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [EXP_W+FRAC_W:0] a,
   input  logic [EXP_W+FRAC_W:0] b,
   output logic                  busy,
   output logic                  done,
   output logic [EXP_W+FRAC_W:0] result
);

   localparam int W_W   = 1 + EXP_W + FRAC_W;
   localparam int MAN_W = FRAC_W + 1;
   localparam int SUM_W = FRAC_W + 2;
   localparam int D_SAT = FRAC_W + 3;
   localparam int D_W   = $clog2(D_SAT + 1);

   localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
   localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
   localparam logic [EXP_W-1:0] D_SAT_E  = EXP_W'(D_SAT);
   localparam logic [D_W-1:0]   D_SAT_V  = D_W'(D_SAT);
   localparam logic [D_W-1:0]   D_ONE    = D_W'(1);
   localparam logic [W_W-1:0]   NAN_WORD = {1'b0, EXP_ONES, 1'b1, {(FRAC_W-1){1'b0}}};

   // Operand fields
   logic              a_sign, b_sign, a_zero, b_zero, a_special, b_special;
   logic [EXP_W-1:0]  a_exp, b_exp;
   logic [MAN_W-1:0]  a_man, b_man;

   fp_unpack #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_unpack_a (
      .word(a), .sign(a_sign), .exp(a_exp), .man(a_man),
      .is_zero(a_zero), .is_special(a_special)
   );

   fp_unpack #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_unpack_b (
      .word(b), .sign(b_sign), .exp(b_exp), .man(b_man),
      .is_zero(b_zero), .is_special(b_special)
   );

   // Swap so X holds the larger magnitude; b's sign is inverted to turn
   // the subtraction into an addition of signed operands.
   logic              x_is_a, x_sign, y_sign;
   logic [EXP_W-1:0]  x_exp, y_exp, exp_diff;
   logic [MAN_W-1:0]  x_man, y_man;

   assign x_is_a   = b_zero | (~a_zero & ({a_exp, a_man} >= {b_exp, b_man}));
   assign x_sign   = x_is_a ? a_sign : ~b_sign;
   assign y_sign   = x_is_a ? ~b_sign : a_sign;
   assign x_exp    = x_is_a ? a_exp : b_exp;
   assign y_exp    = x_is_a ? b_exp : a_exp;
   assign x_man    = x_is_a ? a_man : b_man;
   assign y_man    = x_is_a ? b_man : a_man;
   assign exp_diff = x_exp - y_exp;

   // State and datapath registers
   state_e            state_q, state_d;
   logic              sign_q, sign_d;
   logic              sub_q, sub_d;
   logic [EXP_W-1:0]  exp_q, exp_d;
   logic [MAN_W-1:0]  mx_q, mx_d;
   logic [MAN_W-1:0]  my_q, my_d;
   logic [D_W-1:0]    shift_q, shift_d;
   logic [SUM_W-1:0]  sum_q, sum_d;
   logic [W_W-1:0]    result_q, result_d;

   // Next-state and datapath update for the align/add/normalise sequence.
   always_comb begin
      // NOTE: every _d gets its hold value first so no path leaves one unassigned (no latches).
      state_d  = state_q;
      sign_d   = sign_q;
      sub_d    = sub_q;
      exp_d    = exp_q;
      mx_d     = mx_q;
      my_d     = my_q;
      shift_d  = shift_q;
      sum_d    = sum_q;
      result_d = result_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (a_special || b_special) begin
                  result_d = NAN_WORD;
                  state_d  = DONE;
               end else begin
                  sign_d  = x_sign;
                  sub_d   = x_sign ^ y_sign;
                  exp_d   = x_exp;
                  mx_d    = x_man;
                  my_d    = y_man;
                  shift_d = (exp_diff > D_SAT_E) ? D_SAT_V : exp_diff[D_W-1:0];
                  state_d = ALIGN;
               end
            end
         end

         ALIGN: begin
            if (shift_q != '0) begin
               my_d    = my_q >> 1;
               shift_d = shift_q - D_ONE;
            end else begin
               state_d = ADDSUB;
            end
         end

         ADDSUB: begin
            sum_d   = sub_q ? ({1'b0, mx_q} - {1'b0, my_q})
                            : ({1'b0, mx_q} + {1'b0, my_q});
            state_d = NORM;
         end

         NORM: begin
            if (sum_q == '0) begin
               result_d = '0;
               state_d  = DONE;
            end else if (sum_q[SUM_W-1]) begin
               if ((exp_q + EXP_ONE) == EXP_ONES) begin
                  result_d = {sign_q, EXP_ONES, {FRAC_W{1'b0}}};
                  state_d  = DONE;
               end else begin
                  sum_d = sum_q >> 1;
                  exp_d = exp_q + EXP_ONE;
               end
            end else if (!sum_q[SUM_W-2]) begin
               if ((exp_q - EXP_ONE) == '0) begin
                  result_d = {sign_q, {(W_W-1){1'b0}}};
                  state_d  = DONE;
               end else begin
                  sum_d = sum_q << 1;
                  exp_d = exp_q - EXP_ONE;
               end
            end else begin
               result_d = {sign_q, exp_q, sum_q[FRAC_W-1:0]};
               state_d  = DONE;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Register update with synchronous reset; reset aborts any operation.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      if (reset) begin
         state_q  <= IDLE;
         sign_q   <= 1'b0;
         sub_q    <= 1'b0;
         exp_q    <= '0;
         mx_q     <= '0;
         my_q     <= '0;
         shift_q  <= '0;
         sum_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         sign_q   <= sign_d;
         sub_q    <= sub_d;
         exp_q    <= exp_d;
         mx_q     <= mx_d;
         my_q     <= my_d;
         shift_q  <= shift_d;
         sum_q    <= sum_d;
         result_q <= result_d;
      end
   end

   assign busy   = (state_q != IDLE);
   assign done   = (state_q == DONE);
   assign result = result_q;

endmodule

// File: tb/tb_fsub_seq.sv
// Self-checking bench for fsub_seq: an arithmetic reference model predicts
// result and latency per operation; a per-cycle compare process checks
// busy/done/result, and directed vectors pin the model with literal values.
module tb_fsub_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] result;

   always #5 clk = ~clk;

   fsub_seq dut (
      .clk(clk), .reset(reset), .start(start),
      .a(a), .b(b),
      .busy(busy), .done(done), .result(result)
   );

   int n_checks = 0;
   int n_errors = 0;
   int dut_dones = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: exact arithmetic on integer mantissas; latency counted in
   // clock edges from the accepting edge to the edge that raises done.
   function automatic void model(input logic [31:0] fa, input logic [31:0] fb,
                                 output logic [31:0] r, output int lat);
      int ea, eb, ma, mb, ex, ey, mx, my, e, d, n, sum;
      bit sa, sb, sx, sy, s, fin;
      logic [31:0] ev, sv;
      ea = int'(fa[30:23]);
      eb = int'(fb[30:23]);
      sa = fa[31];
      sb = ~fb[31];
      ma = (ea == 0) ? 0 : (8388608 + int'(fa[22:0]));
      mb = (eb == 0) ? 0 : (8388608 + int'(fb[22:0]));
      r  = 32'h0;
      if (ea == 255 || eb == 255) begin
         r   = 32'h7FC0_0000;
         lat = 0;
         return;
      end
      if ((ea > eb) || (ea == eb && ma >= mb)) begin
         sx = sa; ex = ea; mx = ma; sy = sb; ey = eb; my = mb;
      end else begin
         sx = sb; ex = eb; mx = mb; sy = sa; ey = ea; my = ma;
      end
      d = ex - ey;
      if (d > 26) d = 26;
      my  = my >> d;
      sum = (sx == sy) ? (mx + my) : (mx - my);
      s   = sx;
      e   = ex;
      n   = 0;
      fin = 1'b0;
      while (!fin) begin
         if (sum == 0) begin
            r = 32'h0; fin = 1'b1;
         end else if (sum >= 16777216) begin
            if (e + 1 == 255) begin
               r = {s, 8'hFF, 23'h0}; fin = 1'b1;
            end else begin
               sum = sum / 2; e++; n++;
            end
         end else if (sum < 8388608) begin
            if (e - 1 == 0) begin
               r = {s, 31'h0}; fin = 1'b1;
            end else begin
               sum = sum * 2; e--; n++;
            end
         end else begin
            ev = e;
            sv = sum;
            r  = {s, ev[7:0], sv[22:0]};
            fin = 1'b1;
         end
      end
      lat = 3 + d + n;
   endfunction

   // Model of the handshake: one op in flight, start ignored while busy.
   bit          m_active = 1'b0;
   int          m_cyc = 0;
   int          m_lat = 0;
   logic [31:0] m_res = 32'h0;
   logic [31:0] m_held = 32'h0;

   always @(posedge clk) begin
      if (reset) begin
         m_active = 1'b0;
         m_cyc    = 0;
         m_held   = 32'h0;
      end else if (m_active) begin
         m_cyc++;
         if (m_cyc > m_lat) m_active = 1'b0;
      end else if (start) begin
         model(a, b, m_res, m_lat);
         m_active = 1'b1;
         m_cyc    = 0;
      end
      if (m_active && m_cyc == m_lat) m_held = m_res;
   end

   // Per-cycle comparison of outputs against the model, away from the edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", {31'b0, busy}, {31'b0, m_active});
         check("done", {31'b0, done}, {31'b0, (m_active && m_cyc == m_lat)});
         check("result", result, m_held);
         if (done === 1'b1) dut_dones++;
      end
   end

   // Directed op: called at a negedge with the DUT idle; returns likewise.
   task automatic run_op(input string name, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] exp_res, input int exp_lat);
      logic [31:0] mr;
      int          ml;
      int          k;
      model(av, bv, mr, ml);
      check({name, " model result"}, mr, exp_res);
      check({name, " model latency"}, ml, exp_lat);
      a = av; b = bv; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      a = $urandom;
      b = $urandom;
      k = 0;
      while (done !== 1'b1 && k < 100) begin
         @(negedge clk);
         k++;
      end
      check({name, " latency"}, k, exp_lat);
      check({name, " result"}, result, exp_res);
      @(negedge clk);
   endtask

   initial begin
      int d0;
      reset = 1'b1; start = 1'b0; a = 32'h0; b = 32'h0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      check("reset busy", {31'b0, busy}, 32'h0);
      check("reset done", {31'b0, done}, 32'h0);
      check("reset result", result, 32'h0);
      reset = 1'b0;
      @(negedge clk);

      run_op("3-1",        32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 4);
      run_op("1-(-1)",     32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 4);
      run_op("1.5-1.25",   32'h3FC0_0000, 32'h3FA0_0000, 32'h3E80_0000, 5);
      run_op("1-3",        32'h3F80_0000, 32'h4040_0000, 32'hC000_0000, 4);
      run_op("1-1",        32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 3);
      run_op("inf-1",      32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 0);
      run_op("1-nan",      32'h3F80_0000, 32'h7FC0_0001, 32'h7FC0_0000, 0);
      run_op("overflow",   32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 3);
      run_op("underflow",  32'h0080_0000, 32'h0080_0001, 32'h8000_0000, 3);
      run_op("3-0",        32'h4040_0000, 32'h0000_0000, 32'h4040_0000, 29);
      run_op("0-0",        32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 3);
      run_op("0-1",        32'h0000_0000, 32'h3F80_0000, 32'hBF80_0000, 29);
      run_op("denorm-0",   32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 3);
      run_op("truncate",   32'h3F80_0000, 32'h33C0_0000, 32'h3F80_0000, 27);

      // Start held high while busy: only the first request is taken.
      d0 = dut_dones;
      a = 32'h4040_0000; b = 32'h3F80_0000; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a = 32'h3F80_0000; b = 32'h0000_0000;
      repeat (3) @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      check("busy-start done count", dut_dones - d0, 1);
      check("busy-start result", result, 32'h4000_0000);

      // Reset during a long alignment aborts without a done pulse.
      d0 = dut_dones;
      a = 32'h4B00_0000; b = 32'h3F80_0000; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort busy", {31'b0, busy}, 32'h0);
      check("abort done", {31'b0, done}, 32'h0);
      check("abort result", result, 32'h0);
      reset = 1'b0;
      @(negedge clk);
      check("abort no done", dut_dones - d0, 0);
      run_op("2^23-1",     32'h4B00_0000, 32'h3F80_0000, 32'h4AFF_FFFE, 27);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
